// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: bridge-side register bus of the interrupt controller.
// The bridge drives address, strobes and write data; the controller returns read data.
interface irq_ctrl_if;
    logic [1:0]  Addr;
    logic        WE;
    logic        RE;
    logic [31:0] Din;
    logic [31:0] Dout;
    modport master (output Addr, WE, RE, Din, input Dout);
    modport slave (input Addr, WE, RE, Din, output Dout);
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller with edge/level capture, masking and claim/EOI.
// Define IRQC_ROUND_ROBIN_EN to rotate priority after each EOI instead of fixed source-0-first.
module irq_ctrl #(
    parameter int N_SRC = 6,
    parameter int ID_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] Src,
    irq_ctrl_if.slave        bus,
    output logic             IRQ
);
    typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;
    state_t             r_state;
    logic [N_SRC-1:0]   r_s1, r_s2, r_mask, r_mode, r_pend;
    logic [ID_W-1:0]    r_act_id;
    logic               r_irq;
    logic [N_SRC-1:0]   w_rise, w_elig, w_act_hot, w_w1c, w_clr, w_pend_nx, w_rot;
    logic [2*N_SRC-1:0] w_dbl;
    logic [ID_W-1:0]    w_base, w_pos, w_win;
    logic [ID_W:0]      w_sum;
    logic               w_act_elig, w_claim, w_eoi, w_unused;
    logic [31:0]        w_claim_rd;

    assign w_rise     = r_s1 & ~r_s2;
    assign w_elig     = r_pend & r_mask;
    assign w_act_hot  = N_SRC'(1) << r_act_id;
    assign w_act_elig = |(w_elig & w_act_hot);
    assign w_claim    = bus.RE && !bus.WE && bus.Addr == 2'd3 && r_state == ASSERT && w_act_elig;
    assign w_eoi      = bus.WE && bus.Addr == 2'd3 && r_state == SERVICE && bus.Din[ID_W-1:0] == r_act_id;
    assign w_w1c      = (bus.WE && bus.Addr == 2'd1) ? bus.Din[N_SRC-1:0] : '0;
    assign w_clr      = w_w1c | (w_claim ? w_act_hot : '0);
    // A rise in the same cycle as a clear keeps the bit pending.
    assign w_pend_nx  = (r_mode & (w_rise | (r_pend & ~w_clr))) | (~r_mode & r_s1);
    assign w_claim_rd = (r_state == IDLE) ? '0 : {r_state == ASSERT, {(31-ID_W){1'b0}}, r_act_id};
    assign bus.Dout   = (bus.Addr == 2'd0) ? 32'(r_mask) :
                        (bus.Addr == 2'd1) ? 32'(r_pend) :
                        (bus.Addr == 2'd2) ? 32'(r_mode) : w_claim_rd;
    assign IRQ        = r_irq;
    assign w_unused   = ^{bus.Din, w_dbl[2*N_SRC-1:N_SRC]};

`ifdef IRQC_ROUND_ROBIN_EN
    logic [ID_W-1:0] r_rr_ptr;
    always_ff @(posedge clk or posedge reset)
        if (reset) r_rr_ptr <= '0;
        else if (w_eoi) r_rr_ptr <= (r_act_id == ID_W'(N_SRC - 1)) ? '0 : r_act_id + 1'b1;
    assign w_base = r_rr_ptr;
`else
    assign w_base = '0;
`endif

    // Rotate eligible bits so the search always starts at w_base, then map back.
    assign w_dbl = {w_elig, w_elig} >> w_base;
    assign w_rot = w_dbl[N_SRC-1:0];

    always_comb begin
        w_pos = '0;
        for (int i = N_SRC - 1; i >= 0; i--) w_pos = w_rot[i] ? ID_W'(i) : w_pos;
        w_sum = {1'b0, w_pos} + {1'b0, w_base};
        w_win = (w_sum >= (ID_W+1)'(N_SRC)) ? ID_W'(w_sum - (ID_W+1)'(N_SRC)) : w_sum[ID_W-1:0];
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_mask   <= '0;
            r_mode   <= '0;
            r_pend   <= '0;
            r_state  <= IDLE;
            r_irq    <= 1'b0;
            r_act_id <= '0;
        end else begin
            r_s1   <= Src;
            r_s2   <= r_s1;
            r_pend <= w_pend_nx;
            if (bus.WE && bus.Addr == 2'd0) r_mask <= bus.Din[N_SRC-1:0];
            if (bus.WE && bus.Addr == 2'd2) r_mode <= bus.Din[N_SRC-1:0];
            case (r_state)
                IDLE:
                    if (|w_elig) begin
                        r_act_id <= w_win;
                        r_state  <= ASSERT;
                        r_irq    <= 1'b1;
                    end
                ASSERT:
                    if (!w_act_elig || w_claim) begin
                        r_state <= w_act_elig ? SERVICE : IDLE;
                        r_irq   <= 1'b0;
                    end
                SERVICE:
                    if (w_eoi) r_state <= IDLE;
                default: begin
                    r_state <= IDLE;
                    r_irq   <= 1'b0;
                end
            endcase
        end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed stimulus for irq_ctrl; expectations are queued and checked by a monitor.
`timescale 1ns/1ps
module tb_irq_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Src;
  logic       IRQ;
  irq_ctrl_if bus();
  irq_ctrl dut (.clk(clk), .reset(reset), .Src(Src), .bus(bus), .IRQ(IRQ));
  always #5 clk = ~clk;
  typedef struct {
    bit          irq;
    logic [31:0] exp;
    string       nm;
  } exp_t;
  exp_t q[$];
  event smp;
  int   n_chk = 0;
  int   n_pass = 0;
`ifdef IRQC_ROUND_ROBIN_EN
  localparam logic [31:0] ID_A = 32'd2, ID_B = 32'd0;
`else
  localparam logic [31:0] ID_A = 32'd0, ID_B = 32'd2;
`endif
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $finish;
  end
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk or smp);
      while (q.size() > 0) begin
        e   = q.pop_front();
        act = e.irq ? {31'b0, IRQ} : bus.Dout;
        n_chk++;
        if (act === e.exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", e.nm, act, e.exp);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic now_chk();
    #1;
    ->smp;
    #1;
  endtask
  task automatic exp_irq(input logic v, input string nm);
    q.push_back('{1'b1, {31'b0, v}, nm});
  endtask
  task automatic exp_rd(input logic [1:0] a, input logic [31:0] v, input string nm);
    bus.Addr = a;
    q.push_back('{1'b0, v, nm});
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.Addr = a;
    bus.Din  = d;
    bus.WE   = 1'b1;
    tick();
    bus.WE   = 1'b0;
  endtask
  task automatic claim(input logic [31:0] v, input string nm);
    bus.RE = 1'b1;
    exp_irq(1'b1, nm);
    exp_rd(2'd3, v, nm);
    tick();
    bus.RE = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    Src = '0;
    bus.Addr = '0;
    bus.WE = 1'b0;
    bus.RE = 1'b0;
    bus.Din = '0;
    tick();
    n_chk++;
    if (IRQ === 1'b0 && bus.Dout === 32'h0) n_pass++;
    else $display("FAIL rst_direct: IRQ=%b Dout=%h", IRQ, bus.Dout);
    exp_irq(1'b0, "rst_irq");
    exp_rd(2'd0, 32'h0, "rst_mask");
    tick();
    exp_rd(2'd1, 32'h0, "rst_pend");
    tick();
    exp_rd(2'd3, 32'h0, "rst_claim");
    tick();
    reset = 1'b0;
    tick();
    wr(2'd0, 32'h3F);
    wr(2'd2, 32'h3F);
    Src = 6'h02;
    tick();
    Src = '0;
    exp_irq(1'b0, "t1_irq_k");
    exp_rd(2'd1, 32'h0, "t1_pend_k");
    tick();
    exp_irq(1'b0, "t1_irq_k1");
    exp_rd(2'd1, 32'h2, "t1_pend_k1");
    tick();
    claim(32'h8000_0001, "t1_claim");
    exp_irq(1'b0, "t1_irq_svc");
    exp_rd(2'd1, 32'h0, "t1_pend_clr");
    tick();
    exp_rd(2'd3, 32'h1, "t1_svc_rd");
    tick();
    wr(2'd3, 32'h1);
    exp_irq(1'b0, "t1_idle_irq");
    exp_rd(2'd3, 32'h0, "t1_eoi_idle");
    tick();
    Src = 6'h05;
    tick();
    Src = '0;
    tick();
    tick();
    claim(32'h8000_0000 | ID_A, "t2_claim_a");
    wr(2'd3, ID_A);
    exp_irq(1'b0, "t2_irq_gap");
    tick();
    claim(32'h8000_0000 | ID_B, "t2_claim_b");
    wr(2'd3, 32'h1);
    exp_irq(1'b0, "t4_irq");
    exp_rd(2'd3, ID_B, "t4_mismatch");
    tick();
    wr(2'd3, ID_B);
    exp_rd(2'd3, 32'h0, "t4_eoi");
    tick();
    exp_rd(2'd1, 32'h0, "t4_pend");
    tick();
    wr(2'd0, 32'h0);
    Src = 6'h10;
    tick();
    Src = '0;
    wr(2'd1, 32'h10);
    exp_rd(2'd1, 32'h10, "t5_set_wins");
    tick();
    wr(2'd1, 32'h10);
    exp_rd(2'd1, 32'h0, "t5_w1c");
    tick();
    wr(2'd0, 32'hFFFF_FFFF);
    exp_rd(2'd0, 32'h3F, "t5_mask_bits");
    tick();
    wr(2'd2, 32'hFFFF_FFC0);
    exp_rd(2'd2, 32'h0, "t5_mode_bits");
    tick();
    wr(2'd0, 32'h0);
    Src = 6'h08;
    tick();
    tick();
    exp_rd(2'd1, 32'h8, "t3_pend_lvl");
    exp_irq(1'b0, "t3_masked");
    tick();
    wr(2'd0, 32'h8);
    exp_irq(1'b0, "t3_irq_f");
    tick();
    exp_irq(1'b1, "t3_irq_on");
    exp_rd(2'd3, 32'h8000_0003, "t3_claim_peek");
    tick();
    wr(2'd0, 32'h0);
    exp_irq(1'b1, "t3_irq_e");
    tick();
    exp_irq(1'b0, "t3_irq_off");
    exp_rd(2'd3, 32'h0, "t3_idle");
    tick();
    wr(2'd0, 32'h8);
    exp_irq(1'b0, "t3_irq_f2");
    tick();
    exp_irq(1'b1, "t3_irq_back");
    tick();
    Src = '0;
    tick();
    tick();
    exp_irq(1'b1, "t3_wd_hold");
    exp_rd(2'd1, 32'h0, "t3_pend0");
    tick();
    exp_irq(1'b0, "t3_wd_off");
    tick();
    wr(2'd2, 32'h3F);
    wr(2'd0, 32'h3F);
    Src = 6'h04;
    tick();
    Src = '0;
    tick();
    tick();
    bus.Addr = 2'd3;
    bus.Din = 32'h2;
    bus.WE = 1'b1;
    bus.RE = 1'b1;
    exp_irq(1'b1, "t6_irq");
    tick();
    bus.WE = 1'b0;
    bus.RE = 1'b0;
    exp_irq(1'b1, "t6_we_re");
    exp_rd(2'd3, 32'h8000_0002, "t6_still_assert");
    tick();
    claim(32'h8000_0002, "t6_claim");
    exp_irq(1'b0, "t6_svc_irq");
    exp_rd(2'd3, 32'h2, "t6_svc");
    tick();
    exp_rd(2'd0, 32'h3F, "t6_mask_pre");
    tick();
    bus.Addr = 2'd3;
    reset = 1'b1;
    exp_irq(1'b0, "t6_rst_irq");
    exp_rd(2'd3, 32'h0, "t6_rst_claim");
    now_chk();
    n_chk++;
    if (IRQ === 1'b0) n_pass++;
    else $display("FAIL t6_rst_direct: IRQ=%b", IRQ);
    exp_rd(2'd0, 32'h0, "t6_rst_mask");
    now_chk();
    tick();
    reset = 1'b0;
    tick();
    exp_rd(2'd1, 32'h0, "t6_pend_after");
    tick();
    tick();
    if (n_pass != n_chk) $display("FAIL summary: %0d of %0d checks failed", n_chk - n_pass, n_chk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
